// File: rtl/clk_gen_pkg.sv
// Shared constants for the CPU clock controller: mode encodings and the
// single-step FSM state values.
package clk_gen_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_STEP = 1'b1;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the debug front panel and the clock controller.
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 26
) ();

  logic [1:0]       mode;
  logic [CNT_W-1:0] div;
  logic             div_load;
  logic             step_req;
  logic             clk;
  logic             tick;
  logic             busy;

  modport master (
    output mode, div, div_load, step_req,
    input  clk, tick, busy
  );

  modport slave (
    input  mode, div, div_load, step_req,
    output clk, tick, busy
  );

endinterface

// File: rtl/clk_div_ctrl_rise_detect.sv
// One-flop rising-edge detector for an already-debounced level input.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable core clock divider with run/fast/hold/single-step modes
// and a one-sysclk tick on every rising edge of the divided clock.
module clk_div_ctrl
  import clk_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DIV_DEFAULT = 500
) (
  input  logic          sysclk,
  input  logic          reset,
  clk_div_ctrl_if.slave bus
);

  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] div_r_q, div_r_d;
  logic [CNT_W-1:0] lim;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [0:0]       state_q, state_d;
  logic             step_rise;
  logic             advance;
  logic             wrap;

  rise_detect u_step_rise (
    .clk  (sysclk),
    .rst  (reset),
    .d    (bus.step_req),
    .rise (step_rise)
  );

  always_comb begin
    counter_d = counter_q;
    div_r_d   = div_r_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    state_d   = state_q;
    advance   = 1'b0;
    lim       = div_r_q;

    case (bus.mode)
      MODE_RUN: begin
        advance = 1'b1;
        state_d = S_IDLE;
      end
      MODE_FAST: begin
        advance = 1'b1;
        lim     = '0;
        state_d = S_IDLE;
      end
      MODE_HOLD: begin
        advance = (state_q == S_STEP);
      end
      MODE_STEP: begin
        if (state_q == S_STEP || clk_q) begin
          advance = 1'b1;
        end else if (step_rise) begin
          state_d = S_STEP;
        end
      end
    endcase

    // >= rather than == so entering FAST mid-count snaps straight to 0.
    wrap = (counter_q >= lim);

    if (bus.div_load) begin
      div_r_d   = bus.div;
      counter_d = '0;
      state_d   = state_q;
    end else if (advance) begin
      if (wrap) begin
        counter_d = '0;
        clk_d     = ~clk_q;
        tick_d    = ~clk_q;
        if (clk_q) begin
          state_d = S_IDLE;
        end
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      div_r_q   <= CNT_W'(DIV_DEFAULT);
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      counter_q <= counter_d;
      div_r_q   <= div_r_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
    end
  end

  assign bus.clk  = clk_q;
  assign bus.tick = tick_q;
  assign bus.busy = (state_q == S_STEP);

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Parametrised, run-time programmable clock divider and CPU clock controller. It drives the processor core clock from `sysclk` and supports free-run, fast, hold and single-step modes, so the core can be debugged one cycle at a time from a debounced push-button. It replaces the fixed 501-cycle half-period divider at the top level. It also emits a one-`sysclk` tick aligned with every rising edge of the divided clock, for synchronous consumers in the `sysclk` domain.

## Interface
Parameters:
- `CNT_W`, 26: width of the half-period counter and divisor register.
- `DIV_DEFAULT`, 500: divisor loaded at reset. The half-period is `DIV_DEFAULT+1` sysclk cycles.

Ports:
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  2  00 RUN, 01 STEP, 10 HOLD, 11 FAST; sampled every cycle.
- `div`  in  CNT_W  new half-period divisor (half-period = `div+1` cycles).
- `div_load`  in  1  one-cycle strobe that latches `div` into `div_r`.
- `step_req`  in  1  debounced button level; its rising edge requests one core clock period.
- `clk`  out  1  divided core clock, registered.
- `tick`  out  1  one-cycle pulse, high in the same cycle in which `clk` first reads 1.
- `busy`  out  1  high while a single-step period is in progress.

## Operation
- State: `counter[CNT_W-1:0]`, `div_r[CNT_W-1:0]`, `clk`, `tick`, `step_q` (previous `step_req`), and a 2-state step FSM with states S_IDLE and S_STEP.
- Reset values: `counter`=0, `div_r`=DIV_DEFAULT, `clk`=0, `tick`=0, `busy`=0, `step_q`=0, FSM=S_IDLE.
- Half-period engine, when advancing:
  - If `counter==lim`: `counter`<=0 and `clk`<=~`clk`.
  - Otherwise: `counter`<=`counter`+1.
  - `lim` is `div_r` in RUN and STEP, and 0 in FAST.
- `tick`<=1 only in the cycle that toggles `clk` from 0 to 1. Otherwise `tick`<=0.
- RUN: the engine advances every cycle.
- FAST: the engine advances every cycle, `clk` toggles every cycle (`sysclk`/2), and `counter` is held at 0.
- HOLD:
  - The engine is frozen and `counter` and `clk` keep their values.
  - A pending step completes first: HOLD is ignored while `busy`=1.
- STEP:
  - In S_IDLE with `clk`=0, the engine is frozen.
  - In S_IDLE with `clk`=1, the engine advances until `clk` falls, then freezes. This covers entering STEP mid-high.
  - Step request = `step_req & ~step_q`, evaluated only when S_IDLE, `clk`=0 and mode=STEP. It moves the FSM to S_STEP and sets `busy`=1.
  - In S_STEP the engine advances with `lim`=`div_r`. On the 1→0 toggle of `clk` the FSM returns to S_IDLE and `busy`=0.
  - A step request while `busy`=1 is dropped, not queued.
- Leaving STEP for RUN or FAST while `busy`=1 aborts the step: the FSM goes to S_IDLE, `busy`=0, and `clk` and `counter` continue from their current values.
- `div_load`:
  - `div_r`<=`div` and `counter`<=0. `clk` and the FSM are unchanged.
  - This takes priority over the engine in that cycle, so there is no toggle that cycle.
- Arithmetic is unsigned. `div`=0 is legal and gives toggling every cycle. `counter` never exceeds `div_r`, so it cannot wrap.

## Timing
- All outputs are registered, with zero combinational paths from inputs to outputs.
- Mode and `div_load` act at the next `sysclk` edge (latency 1).
- RUN, `div_r`=N: `clk` period 2(N+1) sysclk cycles, 50 % duty. The first rising edge after reset occurs N+1 cycles after reset release.
- STEP: the first `clk` rise is `div_r`+2 cycles after the `step_req` rising edge (1 cycle detect plus `div_r`+1 count). `clk` is high for exactly `div_r`+1 cycles.
- Asynchronous reset mid-step forces `clk`=0 and `busy`=0 immediately.

## Structure
- Package `clk_gen_pkg`:
  - mode encodings `MODE_RUN`, `MODE_STEP`, `MODE_HOLD`, `MODE_FAST`.
  - FSM state constants `S_IDLE`, `S_STEP`.
- Sub-module `rise_detect`: a one-flop rising-edge detector with async reset, producing the step request from `step_req`. It is reusable for other button inputs.

## Test plan
- Reset, RUN, `DIV_DEFAULT`=500 -> first `clk` rise at cycle 501 after reset release, period 1002, one `tick` per rise and none on falls.
- RUN, `div_load` with `div`=3 in mid high phase -> `counter` clears with no toggle that cycle, then `clk` toggles every 4 cycles.
- STEP, `div_r`=2, `step_req` pulsed high for 10 cycles -> exactly one period: `clk` high 3 cycles, then low and held; `busy` high from the cycle after the edge until the falling toggle; a second edge during `busy` is ignored.
- FAST -> `clk` toggles every cycle; switching to HOLD with `clk`=1 -> `clk` stays 1 and `counter` is frozen.
- `reset` asserted mid-step, asynchronously between edges -> `clk`=0, `busy`=0, `tick`=0 immediately, `div_r` back to 500.
